// File: rtl/microroc_readout_pkg.sv
// ----------------------------------------------------------------------------
// microroc_readout_pkg
// Shared definitions for the Microroc serial readout front-end:
//   - WORD_W                : deserialised word width (16)
//   - DEF_START_PULSE_CYCLES: default START_READOUT pulse width in clocks
//   - DEF_TIMEOUT_CYCLES    : default wait-state timeout in clocks
//   - state_t               : readout FSM state encoding
//   - left_justify()        : moves a partial word from the LSBs to the MSBs
// ----------------------------------------------------------------------------
package microroc_readout_pkg;

  localparam int WORD_W                 = 16;
  localparam int DEF_START_PULSE_CYCLES = 4;
  localparam int DEF_TIMEOUT_CYCLES     = 65535;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_TX  = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_WAIT_END = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  // The shift register collects bits into its LSBs; a partial word of
  // nbits bits is moved up so the first received bit sits at bit 15 and the
  // unfilled LSBs are zero.
  function automatic logic [WORD_W-1:0] left_justify(input logic [WORD_W-1:0] bits,
                                                     input logic [4:0]        nbits);
    logic [4:0] amount;
    amount = 5'(WORD_W) - nbits;
    return bits << amount;
  endfunction

endpackage

// File: rtl/pin_sync2.sv
// ----------------------------------------------------------------------------
// pin_sync2
// Two-flop synchroniser for a bundle of asynchronous input pins. All bits go
// through the same depth so pins that change together stay aligned.
// Ports:
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset (both stages load RST_VAL)
//   i_d     : asynchronous pin inputs
//   o_q     : synchronised outputs, 2 clocks of latency
// ----------------------------------------------------------------------------
module pin_sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/microroc_readout.sv
// ----------------------------------------------------------------------------
// microroc_readout
// Serial readout front-end for the Microroc ASIC RAM. A StartReadout request
// pulses START_READOUT, then DOUT is deserialised MSB first into 16-bit words
// while TRANSMITON (active low) is asserted. END_READOUT or a wait-state
// timeout finishes the readout with a one-cycle EndReadout pulse.
// Ports:
//   Clk, reset_n    : clock, asynchronous active-low reset
//   StartReadout    : one-cycle request, honoured in IDLE only
//   EndReadout      : one-cycle pulse, once per accepted request
//   START_READOUT   : pin to ASIC, high for START_PULSE_CYCLES clocks
//   TRANSMITON      : pin from ASIC, active low, asynchronous
//   DOUT            : serial data pin from ASIC, asynchronous
//   END_READOUT     : pin from ASIC, active high, asynchronous
//   MicrorocData    : last emitted word (held until the next one)
//   MicrorocData_en : one-cycle strobe for MicrorocData
//   WordCount       : words emitted in current/last readout (saturating)
//   ReadoutError    : sticky timeout / partial-word flag, cleared on start
//   dbg_state       : current FSM state (state_t encoding)
// Handshake: MicrorocData_en is a valid-only strobe. There is no ready; the
// consumer must take MicrorocData in every cycle where MicrorocData_en is 1.
// ----------------------------------------------------------------------------
module microroc_readout
  import microroc_readout_pkg::*;
#(
  parameter int START_PULSE_CYCLES = DEF_START_PULSE_CYCLES,
  parameter int TIMEOUT_CYCLES     = DEF_TIMEOUT_CYCLES
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        StartReadout,
  output logic        EndReadout,
  output logic        START_READOUT,
  input  logic        TRANSMITON,
  input  logic        DOUT,
  input  logic        END_READOUT,
  output logic [15:0] MicrorocData,
  output logic        MicrorocData_en,
  output logic [15:0] WordCount,
  output logic        ReadoutError,
  output logic [2:0]  dbg_state
);

  // Synchronised pins: bit 0 TRANSMITON (resets inactive high), bit 1 DOUT,
  // bit 2 END_READOUT.
  logic [2:0] w_pins_sync;
  logic       w_tx_n;
  logic       w_dout;
  logic       w_end;

  pin_sync2 #(
    .W       (3),
    .RST_VAL (3'b001)
  ) u_pin_sync2 (
    .i_clk   (Clk),
    .i_rst_n (reset_n),
    .i_d     ({END_READOUT, DOUT, TRANSMITON}),
    .o_q     (w_pins_sync)
  );

  assign w_tx_n = w_pins_sync[0];
  assign w_dout = w_pins_sync[1];
  assign w_end  = w_pins_sync[2];

  state_t             r_state;
  state_t             w_next_state;
  logic [7:0]         r_pulse_cnt;
  logic [15:0]        r_tmo;
  logic [4:0]         r_bitcnt;
  logic [WORD_W-1:0]  r_shift;
  logic [WORD_W-1:0]  r_data;
  logic               r_en;
  logic [15:0]        r_wcnt;
  logic               r_err;
  logic               r_start_pin;
  logic               r_end_pulse;

  logic               w_tmo_expired;
  logic               w_clear;
  logic               w_shift;
  logic               w_flush;
  logic               w_set_err;
  logic               w_word_full;
  logic [WORD_W-1:0]  w_shift_word;

  assign w_tmo_expired = (r_tmo == 16'(TIMEOUT_CYCLES - 1));
  assign w_shift_word  = {r_shift[WORD_W-2:0], w_dout};
  assign w_word_full   = w_shift && (r_bitcnt == 5'(WORD_W - 1));

  // Next-state and datapath control.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    w_flush      = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (StartReadout) begin
          w_next_state = ST_START;
          w_clear      = 1'b1;
        end
      end
      ST_START: begin
        if (r_pulse_cnt == 8'(START_PULSE_CYCLES - 1)) w_next_state = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        // The synced DOUT in the cycle TRANSMITON is first seen low is the
        // first data bit, so it is captured here rather than in SHIFT.
        if (!w_tx_n) begin
          w_shift      = 1'b1;
          w_next_state = ST_SHIFT;
        end else if (w_tmo_expired) begin
          w_set_err    = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_SHIFT: begin
        if (!w_tx_n) begin
          w_shift = 1'b1;
        end else begin
          w_next_state = ST_WAIT_END;
          if (r_bitcnt != 5'd0) begin
            w_flush   = 1'b1;
            w_set_err = 1'b1;
          end
        end
      end
      ST_WAIT_END: begin
        if (w_end) begin
          w_next_state = ST_DONE;
        end else if (w_tmo_expired) begin
          w_set_err    = 1'b1;
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pulse_cnt <= '0;
      r_tmo       <= '0;
      r_bitcnt    <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_en        <= 1'b0;
      r_wcnt      <= '0;
      r_err       <= 1'b0;
      r_start_pin <= 1'b0;
      r_end_pulse <= 1'b0;
    end else begin
      r_pulse_cnt <= (r_state == ST_START) ? r_pulse_cnt + 8'd1 : 8'd0;

      // Timeout restarts on every state change and only advances while
      // waiting on the chip.
      if (w_next_state != r_state)
        r_tmo <= '0;
      else if (r_state == ST_WAIT_TX || r_state == ST_WAIT_END)
        r_tmo <= r_tmo + 16'd1;

      if (w_clear) begin
        r_bitcnt <= '0;
        r_shift  <= '0;
      end else if (w_shift) begin
        r_shift  <= w_shift_word;
        r_bitcnt <= w_word_full ? 5'd0 : r_bitcnt + 5'd1;
      end else if (w_flush) begin
        r_bitcnt <= '0;
      end

      r_en <= w_word_full | w_flush;
      if (w_word_full)  r_data <= w_shift_word;
      else if (w_flush) r_data <= left_justify(r_shift, r_bitcnt);

      if (w_clear)
        r_wcnt <= '0;
      else if ((w_word_full || w_flush) && r_wcnt != 16'hFFFF)
        r_wcnt <= r_wcnt + 16'd1;

      if (w_clear)        r_err <= 1'b0;
      else if (w_set_err) r_err <= 1'b1;

      r_start_pin <= (w_next_state == ST_START);
      r_end_pulse <= (w_next_state == ST_DONE);
    end
  end

  assign START_READOUT   = r_start_pin;
  assign EndReadout      = r_end_pulse;
  assign MicrorocData    = r_data;
  assign MicrorocData_en = r_en;
  assign WordCount       = r_wcnt;
  assign ReadoutError    = r_err;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_microroc_readout.sv
// ----------------------------------------------------------------------------
// tb_microroc_readout
// Randomised bench for microroc_readout. A driver plays the ASIC side of the
// pins; a reference model turns each bit stream into the expected words,
// which a separate monitor compares against every MicrorocData_en strobe.
// ----------------------------------------------------------------------------
module tb_microroc_readout;

  localparam int PULSE = 4;
  localparam int TMO   = 100;

  logic        Clk;
  logic        reset_n;
  logic        StartReadout;
  logic        EndReadout;
  logic        START_READOUT;
  logic        TRANSMITON;
  logic        DOUT;
  logic        END_READOUT;
  logic [15:0] MicrorocData;
  logic        MicrorocData_en;
  logic [15:0] WordCount;
  logic        ReadoutError;
  logic [2:0]  dbg_state;

  microroc_readout #(
    .START_PULSE_CYCLES (PULSE),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .Clk             (Clk),
    .reset_n         (reset_n),
    .StartReadout    (StartReadout),
    .EndReadout      (EndReadout),
    .START_READOUT   (START_READOUT),
    .TRANSMITON      (TRANSMITON),
    .DOUT            (DOUT),
    .END_READOUT     (END_READOUT),
    .MicrorocData    (MicrorocData),
    .MicrorocData_en (MicrorocData_en),
    .WordCount       (WordCount),
    .ReadoutError    (ReadoutError),
    .dbg_state       (dbg_state)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic        bits_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_end    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clk) begin
    if (reset_n) begin
      if (MicrorocData_en) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL spurious_en: got word %0h with no word expected", MicrorocData);
        end else begin
          check("word", {16'd0, MicrorocData}, {16'd0, exp_q.pop_front()});
        end
      end
      if (EndReadout) n_end++;
    end
  end

  // ---------------- reference model ----------------
  // Splits the first n bits of bits_q into 16-bit words, first bit at the
  // MSB; a trailing partial word is zero-filled at the bottom.
  task automatic model_push(input int n);
    logic [15:0] word;
    int idx;
    for (int w = 0; w < (n + 15) / 16; w++) begin
      word = '0;
      for (int b = 0; b < 16; b++) begin
        idx = w * 16 + b;
        if (idx < n) word[15 - b] = bits_q[idx];
      end
      exp_q.push_back(word);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic pulse_start();
    @(negedge Clk);
    StartReadout = 1'b1;
    @(negedge Clk);
    StartReadout = 1'b0;
  endtask

  // Waits out the START_READOUT pulse and checks its width; returns at the
  // first negedge with the pin low (first WAIT_TX cycle).
  task automatic wait_start_pulse();
    int w;
    w = 0;
    while (START_READOUT && w < 300) begin
      w++;
      @(negedge Clk);
    end
    check("start_pulse_width", w, PULSE);
  endtask

  task automatic drive_bits(input int n, input bit spam);
    for (int i = 0; i < n; i++) begin
      TRANSMITON   = 1'b0;
      DOUT         = bits_q[i];
      StartReadout = (spam && i == n / 2);
      @(negedge Clk);
    end
    TRANSMITON   = 1'b1;
    StartReadout = 1'b0;
    DOUT         = 1'($urandom);
  endtask

  // One full readout using the bits in bits_q.
  task automatic do_readout(input bit tx_on, input bit end_on, input bit spam, input int end_delay);
    int n;
    int k;
    int end_before;
    int exp_cnt;
    bit exp_err;
    n          = tx_on ? bits_q.size() : 0;
    exp_cnt    = (n + 15) / 16;
    exp_err    = !tx_on || (n % 16 != 0) || !end_on;
    end_before = n_end;
    model_push(n);

    pulse_start();
    check("start_pin_rise", START_READOUT, 1);
    check("count_cleared", WordCount, 0);
    check("error_cleared", ReadoutError, 0);
    wait_start_pulse();

    if (!tx_on) begin
      k = 0;
      while (!EndReadout && k < 300) begin
        @(negedge Clk);
        k++;
      end
      check("tx_timeout_latency", k, TMO);
    end else begin
      repeat ($urandom_range(0, 20)) @(negedge Clk);
      drive_bits(n, spam);
      if (end_on) begin
        repeat (end_delay) @(negedge Clk);
        END_READOUT = 1'b1;
      end
      k = 0;
      while (!EndReadout && k < 1000) begin
        @(negedge Clk);
        k++;
      end
      check("end_seen", EndReadout, 1);
    end
    END_READOUT = 1'b0;
    check("word_count", WordCount, exp_cnt);
    check("readout_error", ReadoutError, exp_err);
    repeat (3) @(negedge Clk);
    check("end_pulses", n_end - end_before, 1);
    check("words_drained", exp_q.size(), 0);
  endtask

  task automatic random_bits(input int n);
    bits_q.delete();
    for (int i = 0; i < n; i++) bits_q.push_back(1'($urandom));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] pat;
    int end_before;

    reset_n      = 1'b0;
    StartReadout = 1'b0;
    TRANSMITON   = 1'b1;
    DOUT         = 1'b0;
    END_READOUT  = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_start_pin", START_READOUT, 0);
    check("rst_end", EndReadout, 0);
    check("rst_data", MicrorocData, 0);
    check("rst_en", MicrorocData_en, 0);
    check("rst_count", WordCount, 0);
    check("rst_error", ReadoutError, 0);
    check("rst_state", dbg_state, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge Clk);

    // Nominal: 160 bits of a known pattern, END_READOUT 20 cycles later.
    bits_q.delete();
    for (int w = 0; w < 10; w++) begin
      pat = 16'hA5C3 ^ 16'(w * 16'h1357);
      for (int b = 15; b >= 0; b--) bits_q.push_back(pat[b]);
    end
    do_readout(1'b1, 1'b1, 1'b0, 20);

    // Partial word: 20 bits ending in 1011.
    random_bits(16);
    bits_q.push_back(1'b1);
    bits_q.push_back(1'b0);
    bits_q.push_back(1'b1);
    bits_q.push_back(1'b1);
    do_readout(1'b1, 1'b1, 1'b0, 5);
    check("partial_word", MicrorocData, 16'hB000);

    // No response from the chip.
    bits_q.delete();
    do_readout(1'b0, 1'b0, 1'b0, 0);

    // 32 clean bits but END_READOUT never arrives.
    random_bits(32);
    do_readout(1'b1, 1'b0, 1'b0, 0);

    // StartReadout spam while shifting.
    random_bits(48);
    do_readout(1'b1, 1'b1, 1'b1, 3);

    // Reset after 8 bits of SHIFT.
    random_bits(8);
    end_before = n_end;
    pulse_start();
    wait_start_pulse();
    drive_bits(8, 1'b0);
    TRANSMITON = 1'b0;
    reset_n    = 1'b0;
    #1;
    check("mid_rst_start_pin", START_READOUT, 0);
    check("mid_rst_end", EndReadout, 0);
    check("mid_rst_data", MicrorocData, 0);
    check("mid_rst_en", MicrorocData_en, 0);
    check("mid_rst_count", WordCount, 0);
    check("mid_rst_error", ReadoutError, 0);
    check("mid_rst_state", dbg_state, 0);
    TRANSMITON = 1'b1;
    repeat (3) @(negedge Clk);
    reset_n = 1'b1;
    repeat (5) @(negedge Clk);
    check("mid_rst_no_end", n_end - end_before, 0);
    random_bits(16);
    do_readout(1'b1, 1'b1, 1'b0, 0);

    // Random readouts.
    for (int t = 0; t < 6; t++) begin
      random_bits($urandom_range(1, 64));
      do_readout(1'b1, 1'b1, 1'($urandom), $urandom_range(0, 30));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
